// File: rtl/sync_pulse_if.sv
// Video timing bundle from sync_pulse to the pixel generator and pin drivers.
// master drives the timing outputs, slave observes them.
interface sync_pulse_if #(
  parameter int CNT_W = 10
);
  logic             H_Sync;
  logic             V_Sync;
  logic             Active_Video;
  logic             Frame_Start;
  logic [CNT_W-1:0] Col_Count;
  logic [CNT_W-1:0] Row_Count;

  modport master (
    output H_Sync, V_Sync, Active_Video, Frame_Start, Col_Count, Row_Count
  );

  modport slave (
    input H_Sync, V_Sync, Active_Video, Frame_Start, Col_Count, Row_Count
  );
endinterface

// File: rtl/sync_pulse.sv
// VGA timing generator: free-running column/row counters decoded into sync,
// active-video and frame-start flags, all registered in step with the counters.
module sync_pulse #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic        CLK,
  input  logic        RST,
  sync_pulse_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  // Sync end bounds may equal the total, so they carry one extra bit.
  localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic hs_level(input logic [CNT_W-1:0] col);
    return (col >= HS_START && {1'b0, col} < HS_END) ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic vs_level(input logic [CNT_W-1:0] row);
    return (row >= VS_START && {1'b0, row} < VS_END) ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             av_q, av_d;
  logic             fs_q, fs_d;

  // Flags decode the next counter values so they land on the same edge.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      col_d = '0;
      row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
    end
    hs_d = hs_level(col_d);
    vs_d = vs_level(row_d);
    av_d = (col_d < H_ACT) && (row_d < V_ACT);
    fs_d = (col_d == '0) && (row_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q <= '0;
      row_q <= '0;
      hs_q  <= hs_level('0);
      vs_q  <= vs_level('0);
      av_q  <= (H_ACTIVE > 0) && (V_ACTIVE > 0);
      fs_q  <= 1'b1;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      av_q  <= av_d;
      fs_q  <= fs_d;
    end
  end

  assign vga.Col_Count    = col_q;
  assign vga.Row_Count    = row_q;
  assign vga.H_Sync       = hs_q;
  assign vga.V_Sync       = vs_q;
  assign vga.Active_Video = av_q;
  assign vga.Frame_Start  = fs_q;

endmodule

// File: tb/tb_sync_pulse.sv
// Bench for sync_pulse: a default 640x480 instance and a tiny-timing instance
// run side by side against a per-cycle reference model and event timing checks.
module tb_sync_pulse;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp;
  int n_err;

  sync_pulse_if #(.CNT_W(10)) vga_a ();
  sync_pulse_if #(.CNT_W(4))  vga_b ();

  sync_pulse u_a (
    .CLK (clk),
    .RST (rst_a),
    .vga (vga_a)
  );

  sync_pulse #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .SYNC_POL (1'b1),
    .CNT_W    (4)
  ) u_b (
    .CLK (clk),
    .RST (rst_b),
    .vga (vga_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  localparam logic [31:0] MARK = 32'h0100_0000;

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic av,
                                       input logic fs, input logic [11:0] c,
                                       input logic [11:0] r, input logic mark);
    return {hs, vs, av, fs, 3'b000, mark, c, r};
  endfunction

  function automatic logic [31:0] model(input int c, input int r, input int ha, input int hf,
                                        input int hw, input int va, input int vf,
                                        input int vw, input logic pol, input logic mark);
    logic hs;
    logic vs;
    hs = (c >= ha + hf && c < ha + hf + hw) ? pol : ~pol;
    vs = (r >= va + vf && r < va + vf + vw) ? pol : ~pol;
    return pack(hs, vs, (c < ha) && (r < va), (c == 0) && (r == 0), 12'(c), 12'(r), mark);
  endfunction

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  int ca, ra_row;
  int cb, rb_row;

  // Driver: set reset inputs, advance the model for the coming edge, push.
  task automatic step(input bit ra, input bit rb);
    rst_a = ra;
    rst_b = rb;
    if (ra) begin
      ca = 0; ra_row = 0;
    end else begin
      ca++;
      if (ca == 800) begin
        ca = 0;
        ra_row++;
        if (ra_row == 525) ra_row = 0;
      end
    end
    if (rb) begin
      cb = 0; rb_row = 0;
    end else begin
      cb++;
      if (cb == 14) begin
        cb = 0;
        rb_row++;
        if (rb_row == 7) rb_row = 0;
      end
    end
    exp_a_q.push_back(model(ca, ra_row, 640, 16, 96, 480, 10, 2, 1'b0, ra));
    exp_b_q.push_back(model(cb, rb_row, 8, 2, 3, 4, 1, 1, 1'b1, rb));
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / event tracking ----------------
  int cyc_a, a_fall1, a_rise1, a_fall2, a_av_fall;
  logic a_prev_hs, a_prev_av;
  int cyc_b, b_fs2, b_vs_rise, b_vs_fall, b_hs_rise, b_hs_fall, b_hs_cnt, b_av_cnt;
  logic b_prev_hs, b_prev_vs;

  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] g;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      g = pack(vga_a.H_Sync, vga_a.V_Sync, vga_a.Active_Video, vga_a.Frame_Start,
               12'(vga_a.Col_Count), 12'(vga_a.Row_Count), 1'b0);
      check("a_outputs", g, e & ~MARK);
      if ((e & MARK) != 0) begin
        cyc_a = 0; a_fall1 = -1; a_rise1 = -1; a_fall2 = -1; a_av_fall = -1;
      end else begin
        cyc_a++;
        if (a_prev_hs && !vga_a.H_Sync) begin
          if (a_fall1 < 0) a_fall1 = cyc_a;
          else if (a_fall2 < 0) a_fall2 = cyc_a;
        end
        if (!a_prev_hs && vga_a.H_Sync && a_rise1 < 0) a_rise1 = cyc_a;
        if (a_prev_av && !vga_a.Active_Video && a_av_fall < 0) a_av_fall = cyc_a;
      end
      a_prev_hs = vga_a.H_Sync;
      a_prev_av = vga_a.Active_Video;
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      g = pack(vga_b.H_Sync, vga_b.V_Sync, vga_b.Active_Video, vga_b.Frame_Start,
               12'(vga_b.Col_Count), 12'(vga_b.Row_Count), 1'b0);
      check("b_outputs", g, e & ~MARK);
      if ((e & MARK) != 0) begin
        cyc_b = 0; b_fs2 = -1; b_vs_rise = -1; b_vs_fall = -1;
        b_hs_rise = -1; b_hs_fall = -1; b_hs_cnt = 0;
        b_av_cnt = vga_b.Active_Video ? 1 : 0;
      end else begin
        cyc_b++;
        if (vga_b.Frame_Start && b_fs2 < 0) b_fs2 = cyc_b;
        if (cyc_b < 98) begin
          if (vga_b.Active_Video) b_av_cnt++;
          if (!b_prev_hs && vga_b.H_Sync) b_hs_cnt++;
        end
        if (!b_prev_hs && vga_b.H_Sync && b_hs_rise < 0) b_hs_rise = cyc_b;
        if (b_prev_hs && !vga_b.H_Sync && b_hs_fall < 0) b_hs_fall = cyc_b;
        if (!b_prev_vs && vga_b.V_Sync && b_vs_rise < 0) b_vs_rise = cyc_b;
        if (b_prev_vs && !vga_b.V_Sync && b_vs_fall < 0) b_vs_fall = cyc_b;
      end
      b_prev_hs = vga_b.H_Sync;
      b_prev_vs = vga_b.V_Sync;
    end
  end

  task automatic check_events(input string phase);
    check({phase, "_a_hs_fall"},  32'(a_fall1),   32'd656);
    check({phase, "_a_hs_rise"},  32'(a_rise1),   32'd752);
    check({phase, "_a_hs_fall2"}, 32'(a_fall2),   32'd1456);
    check({phase, "_a_av_fall"},  32'(a_av_fall), 32'd640);
    check({phase, "_b_frame"},    32'(b_fs2),     32'd98);
    check({phase, "_b_hs_rise"},  32'(b_hs_rise), 32'd10);
    check({phase, "_b_hs_fall"},  32'(b_hs_fall), 32'd13);
    check({phase, "_b_hs_cnt"},   32'(b_hs_cnt),  32'd7);
    check({phase, "_b_vs_rise"},  32'(b_vs_rise), 32'd70);
    check({phase, "_b_vs_fall"},  32'(b_vs_fall), 32'd84);
    check({phase, "_b_av_cnt"},   32'(b_av_cnt),  32'd32);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ca = 0; ra_row = 0; cb = 0; rb_row = 0;
    a_prev_hs = 1'b1; a_prev_av = 1'b1;
    b_prev_hs = 1'b0; b_prev_vs = 1'b0;
    #1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    // A reaches row 2 col 300; B is mid-frame on row 2.
    for (int i = 0; i < 1900; i++) step(1'b0, 1'b0);
    @(negedge clk); #1;
    check_events("run1");

    step(1'b1, 1'b1);
    for (int i = 0; i < 1500; i++) step(1'b0, 1'b0);
    @(negedge clk); #1;
    check_events("run2");

    // B alone reset on a random cycle; A keeps running through it.
    for (int i = 0; i < int'($urandom_range(1, 60)); i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
    @(negedge clk); #1;
    check("b_frame_rst3", 32'(b_fs2), 32'd98);
    check("b_av_cnt_rst3", 32'(b_av_cnt), 32'd32);

    check("queue_a_drained", 32'(exp_a_q.size()), 32'd0);
    check("queue_b_drained", 32'(exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_pulse.md
Name:
sync_pulse

Overview:
- VGA timing generator: free-running pixel-column and line counters, decoded into horizontal/vertical sync pulses, an active-video flag and a frame-start strobe.
- Default timing is 640x480 @ 60 Hz, driven by a 25 MHz pixel clock (40 ns period).
- Sits between the pixel-clock domain root and the pattern/pixel generator and DAC/pin drivers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of H_Sync/V_Sync (0 = active-low)
- CNT_W, 10, width of the column/row counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- CLK  in  1  pixel clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- H_Sync  out  1  horizontal sync
- V_Sync  out  1  vertical sync
- Active_Video  out  1  high while column < H_ACTIVE and row < V_ACTIVE
- Col_Count  out  CNT_W  current column, 0..H_TOTAL-1
- Row_Count  out  CNT_W  current row, 0..V_TOTAL-1
- Frame_Start  out  1  high for exactly the one cycle where column = 0 and row = 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset: on a rising edge with RST=1, Col_Count and Row_Count become 0.
  - Outputs then show the (0,0) decode: H_Sync and V_Sync deasserted (default 1), Active_Video=1, Frame_Start=1.
  - Reset has priority over counting.
  - Reset mid-frame restarts at (0,0) on the next edge with no partial-line artefacts.
- Column counter:
  - Increments by 1 every clock.
  - At H_TOTAL-1 it wraps to 0 and the row counter advances by 1.
- Row counter:
  - Changes only on a column wrap.
  - At V_TOTAL-1 (when the column also wraps) it wraps to 0.
- Column and row wrap at the same edge at end of frame; the next state is (0,0).
- H_Sync is asserted (= SYNC_POL) iff H_ACTIVE+H_FP <= column < H_ACTIVE+H_FP+H_SYNC (default columns 656..751); otherwise ~SYNC_POL.
- V_Sync is asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (default rows 490..491, the whole line including blanking); otherwise ~SYNC_POL.
- All outputs are a pure function of the current counter registers.
  - Implementation registers them in step with the counters (next-state decode), so there is zero-cycle skew between Col_Count/Row_Count and the flags, and no combinational glitches on the output pins.
- Arithmetic: unsigned, CNT_W bits; no overflow is possible given the width requirement.
- There are no enable/handshake signals; the block runs continuously whenever RST=0.

Test Plan:
- Reset for 2 cycles, release -> Col=0, Row=0, H_Sync=1, V_Sync=1, Active_Video=1, Frame_Start=1 on the first cycle; Frame_Start=0 from cycle 1.
- Free-run from reset release (cycle 0, 25 MHz) -> first H_Sync low at cycle 656 (26.24 us).
  - Stays low 96 cycles and returns high at cycle 752.
  - Repeats every 800 cycles; the low period contains exactly one pulse per line.
- Free-run -> V_Sync low from cycle 392000 (row 490, col 0) for 1600 cycles; high again at cycle 393600.
  - Exactly one V_Sync pulse per 420000-cycle frame.
  - Frame_Start re-asserts at cycle 420000.
- Active_Video check:
  - Goes 0 at col 640 of every line and returns 1 at col 0 for rows < 480.
  - Stays 0 for all of rows 480..524.
  - Total active cycles per frame = 307200.
- Assert RST at row 100, col 300 for 1 cycle -> next edge Col=0, Row=0, Frame_Start=1; timing resumes identical to the post-reset sequence.
- Override parameters (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=1):
  - H_TOTAL=14; H_Sync high at cols 10..12.
  - V_Sync high on row 5.
  - Frame length = 98 cycles.
